// File: rtl/kanagawa_sim_valid_arbiter.sv
// rtl/kanagawa_sim_valid_arbiter.sv - round-robin merge of valid-only streams through per-port FIFOs
module kanagawa_sim_valid_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear_in,
    input  logic [NUM_PORTS-1:0]           valid_in,
    input  logic [NUM_PORTS*WIDTH-1:0]     data_in,
    input  logic                           stall_in,
    output logic                           valid_out,
    output logic [WIDTH-1:0]               data_out,
    output logic [$clog2(NUM_PORTS)-1:0]   port_out,
    output logic [NUM_PORTS-1:0]           overflow_out,
    output logic [15:0]                    drop_count_out
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef logic [WIDTH-1:0] word_t;

    word_t          mem_q      [NUM_PORTS][FIFO_DEPTH];
    word_t          mem_d      [NUM_PORTS][FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr_q   [NUM_PORTS];
    logic [AW-1:0]  rd_ptr_d   [NUM_PORTS];
    logic [AW-1:0]  wr_ptr_q   [NUM_PORTS];
    logic [AW-1:0]  wr_ptr_d   [NUM_PORTS];
    logic [CW-1:0]  count_q    [NUM_PORTS];
    logic [CW-1:0]  count_d    [NUM_PORTS];
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic           valid_q, valid_d;
    word_t          data_q, data_d;
    logic [PW-1:0]  port_q, port_d;
    logic [NUM_PORTS-1:0] overflow_q, overflow_d;
    logic [15:0]    drop_q, drop_d;

    logic           grant_valid;
    logic [PW-1:0]  grant_idx;

    // Eligibility looks only at registered occupancy, so a push never bypasses to the output.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!grant_valid && !stall_in && count_q[idx] != '0) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

    always_comb begin
        logic        pop;
        logic        full;
        logic        push;
        logic [4:0]  n_drop;
        logic [16:0] drop_sum;
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        rr_ptr_d   = rr_ptr_q;
        valid_d    = grant_valid;
        data_d     = '0;
        port_d     = '0;
        pop        = 1'b0;
        full       = 1'b0;
        push       = 1'b0;
        n_drop     = '0;

        if (grant_valid) begin
            data_d   = mem_q[grant_idx][rd_ptr_q[grant_idx]];
            port_d   = grant_idx;
            rr_ptr_d = (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end

        for (int p = 0; p < NUM_PORTS; p++) begin
            pop  = grant_valid && (grant_idx == PW'(p));
            full = (count_q[p] == CW'(FIFO_DEPTH));
            // A full FIFO still takes the push when its head leaves on the same edge.
            push = valid_in[p] && (!full || pop);
            if (pop) rd_ptr_d[p] = rd_ptr_q[p] + 1'b1;
            if (push) begin
                mem_d[p][wr_ptr_q[p]] = data_in[p*WIDTH +: WIDTH];
                wr_ptr_d[p]           = wr_ptr_q[p] + 1'b1;
            end
            count_d[p] = count_q[p] + CW'(push) - CW'(pop);
            if (valid_in[p] && full && !pop) begin
                overflow_d[p] = 1'b1;
                n_drop        = n_drop + 5'd1;
            end
        end

        drop_sum = {1'b0, drop_q} + 17'(n_drop);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

        if (clear_in) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rd_ptr_d[p] = '0;
                wr_ptr_d[p] = '0;
                count_d[p]  = '0;
            end
            rr_ptr_d   = '0;
            valid_d    = 1'b0;
            data_d     = '0;
            port_d     = '0;
            overflow_d = '0;
            drop_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rd_ptr_q[p] <= '0;
                wr_ptr_q[p] <= '0;
                count_q[p]  <= '0;
            end
            rr_ptr_q   <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            port_q     <= '0;
            overflow_q <= '0;
            drop_q     <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                rd_ptr_q[p] <= rd_ptr_d[p];
                wr_ptr_q[p] <= wr_ptr_d[p];
                count_q[p]  <= count_d[p];
            end
            rr_ptr_q   <= rr_ptr_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            port_q     <= port_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign valid_out      = valid_q;
    assign data_out       = data_q;
    assign port_out       = port_q;
    assign overflow_out   = overflow_q;
    assign drop_count_out = drop_q;

endmodule

// File: tb/tb_kanagawa_sim_valid_arbiter.sv
// tb/tb_kanagawa_sim_valid_arbiter.sv - scoreboard bench with queue-based reference model
module tb_kanagawa_sim_valid_arbiter;

    localparam int NP = 4;
    localparam int W  = 32;
    localparam int D  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear_in = 1'b0;
    logic [NP-1:0]   valid_in = '0;
    logic [NP*W-1:0] data_in = '0;
    logic            stall_in = 1'b0;
    logic            valid_out;
    logic [W-1:0]    data_out;
    logic [1:0]      port_out;
    logic [NP-1:0]   overflow_out;
    logic [15:0]     drop_count_out;

    kanagawa_sim_valid_arbiter #(.NUM_PORTS(NP), .WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .clear_in(clear_in), .valid_in(valid_in),
        .data_in(data_in), .stall_in(stall_in), .valid_out(valid_out),
        .data_out(data_out), .port_out(port_out), .overflow_out(overflow_out),
        .drop_count_out(drop_count_out)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntotal = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        int          cyc;
        int          port;
        logic [31:0] data;
    } exp_t;

    logic [31:0]  mq [NP][$];
    exp_t         exp_q [$];
    int           cyc = 0;
    int           m_rr = 0;
    int           m_drops = 0;
    logic [NP-1:0] m_ovf = '0;

    // Reference model: per-port queues, grant decided before this edge's pushes.
    always @(posedge clk) begin
        int g;
        cyc++;
        if (!rst_n || clear_in) begin
            for (int p = 0; p < NP; p++) mq[p].delete();
            exp_q.delete();
            m_rr = 0;
            m_drops = 0;
            m_ovf = '0;
        end else begin
            g = -1;
            if (!stall_in)
                for (int k = 0; k < NP; k++)
                    if (g < 0 && mq[(m_rr + k) % NP].size() > 0) g = (m_rr + k) % NP;
            if (g >= 0) begin
                exp_t e;
                e.cyc = cyc;
                e.port = g;
                e.data = mq[g].pop_front();
                exp_q.push_back(e);
                m_rr = (g + 1) % NP;
            end
            for (int p = 0; p < NP; p++)
                if (valid_in[p]) begin
                    if (mq[p].size() < D) mq[p].push_back(data_in[p*W +: W]);
                    else begin
                        m_ovf[p] = 1'b1;
                        if (m_drops < 65535) m_drops++;
                    end
                end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("overflow_flags", overflow_out, m_ovf);
            chk("drop_count", drop_count_out, m_drops);
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_port", port_out, e.port);
                    chk("out_data", data_out, e.data);
                    chk("out_cycle", cyc, e.cyc);
                end
            end else begin
                chk("idle_zero", {data_out, 30'd0, port_out}, 64'd0);
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    void'(exp_q.pop_front());
                    chk("missing_output", 1'b0, 1'b1);
                end
            end
        end
    end

    task automatic drive(input logic [NP-1:0] v, input logic [NP*W-1:0] d,
                         input logic st, input logic clr);
        valid_in = v;
        data_in  = d;
        stall_in = st;
        clear_in = clr;
        @(negedge clk);
        valid_in = '0;
        clear_in = 1'b0;
    endtask

    task automatic push_one(input int port, input logic [31:0] val, input logic st);
        logic [NP*W-1:0] d;
        d = '0;
        d[port*W +: W] = val;
        drive(NP'(1 << port), d, st, 1'b0);
    endtask

    task automatic do_clear();
        drive('0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [NP*W-1:0] d;
        int nv;

        @(negedge clk);
        #1;
        chk("reset_outputs", {valid_out, data_out, port_out, overflow_out, drop_count_out}, 55'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single-port latency
        push_one(2, 32'hA5A5_0002, 1'b0);
        chk("lat_not_yet", valid_out, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        chk("lat_valid", valid_out, 1'b1);
        chk("lat_data", data_out, 32'hA5A5_0002);
        chk("lat_port", port_out, 2'd2);
        repeat (4) drive('0, '0, 1'b0, 1'b0);

        // round-robin fairness
        do_clear();
        for (int n = 0; n < 3; n++) begin
            for (int p = 0; p < NP; p++) d[p*W +: W] = 32'h100 * p + n;
            drive('1, d, 1'b1, 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            drive('0, '0, 1'b0, 1'b0);
            chk("rr_port", {valid_out, port_out}, {1'b1, 2'(i % NP)});
        end
        repeat (2) drive('0, '0, 1'b0, 1'b0);

        // overflow and sticky flag
        do_clear();
        for (int n = 0; n < 6; n++) push_one(1, 32'hB000 + n, 1'b1);
        chk("ovf_flag", overflow_out, 4'b0010);
        chk("ovf_drops", drop_count_out, 16'd2);
        repeat (6) drive('0, '0, 1'b0, 1'b0);
        chk("ovf_sticky", {overflow_out, drop_count_out}, {4'b0010, 16'd2});
        do_clear();
        chk("ovf_cleared", {overflow_out, drop_count_out}, 20'd0);

        // full FIFO with concurrent pop
        for (int n = 0; n < D; n++) push_one(0, 32'hC000 + n, 1'b1);
        for (int n = 0; n < 10; n++) begin
            push_one(0, 32'hC100 + n, 1'b0);
            chk("full_pop_valid", valid_out, 1'b1);
        end
        chk("full_pop_no_ovf", overflow_out, 4'b0000);
        repeat (6) drive('0, '0, 1'b0, 1'b0);

        // stall window
        do_clear();
        for (int n = 0; n < D; n++) begin
            d = '0;
            d[0 +: W] = 32'hD000 + n;
            d[W +: W] = 32'hD100 + n;
            drive(4'b0011, d, 1'b1, 1'b0);
        end
        repeat (3) drive('0, '0, 1'b0, 1'b0);
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            drive('0, '0, 1'b1, 1'b0);
            if (valid_out) nv++;
        end
        chk("stall_gap", nv, 0);
        drive('0, '0, 1'b0, 1'b0);
        chk("stall_resume", {valid_out, port_out}, {1'b1, 2'd1});
        repeat (6) drive('0, '0, 1'b0, 1'b0);

        // drop count 7 then clear
        do_clear();
        repeat (D) drive('1, '0, 1'b1, 1'b0);
        drive('1, '0, 1'b1, 1'b0);
        drive(4'b0111, '0, 1'b1, 1'b0);
        chk("drop7", drop_count_out, 16'd7);
        chk("drop7_ovf", overflow_out, 4'b1111);
        drive('0, '0, 1'b0, 1'b1);
        chk("clear_zero", {overflow_out, drop_count_out}, 20'd0);

        // asynchronous reset mid-stream
        for (int n = 0; n < D; n++) push_one(0, 32'hE000 + n, 1'b1);
        drive('0, '0, 1'b0, 1'b0);
        chk("pre_reset_valid", valid_out, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", valid_out, 1'b0);
        chk("async_reset_data", data_out, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            drive('0, '0, 1'b0, 1'b0);
            if (valid_out) nv++;
        end
        chk("post_reset_silent", nv, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NP; p++) d[p*W +: W] = $urandom;
            drive(NP'($urandom_range(0, 15)), d, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 99) == 0));
        end
        repeat (20) drive('0, '0, 1'b0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
